riscv_if: RTL and testbench



---
 rtl/riscv_if.sv | 178 +++++++++++++++++
 tb/tb_riscv_if.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_if
// Description : Instruction-fetch stage. Issues word fetches over a
//               valid/ready request channel, buffers in-order responses in
//               a small FIFO and drives the IF/ID pipeline register. Handles
//               decode stalls and branch redirects, discarding stale words.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_if #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] PC_ID_o,
    output logic [XLEN-1:0] instr_ID_o,
    output logic            instr_valid_o
);

    localparam int unsigned    PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned    CNT_W        = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_d    [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_instr_d [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_id_q, pc_id_d;
    logic [XLEN-1:0]  instr_id_q, instr_id_d;
    logic             instr_valid_q, instr_valid_d;

    logic [CNT_W:0]   credit_used;
    logic [XLEN-1:0]  redirect_target;
    logic             req_valid;
    logic             accept;
    logic             rsp;
    logic             push;
    logic             pop;

    // Outstanding requests plus buffered words may never exceed the FIFO size,
    // which guarantees every returning word has a slot.
    assign credit_used     = {1'b0, outstanding_q} + {1'b0, count_q};
    assign req_valid       = !redirect_i && (credit_used < CREDIT_LIMIT);
    assign accept          = req_valid && imem_req_ready_i;
    assign rsp             = imem_rsp_valid_i && (outstanding_q != '0);
    assign push            = rsp && (drop_q == '0) && !redirect_i;
    assign pop             = !redirect_i && !stall_i && (count_q != '0);
    assign redirect_target = redirect_pc_i & ~XLEN'(3);

    // Next-state: fetch PC, credit/drop counters, FIFO and IF/ID register.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        pc_id_d       = pc_id_q;
        instr_id_d    = instr_id_q;
        instr_valid_d = instr_valid_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        case ({accept, rsp})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_i) begin
            // Every request still in flight after this edge returns a stale word.
            fetch_pc_d    = redirect_target;
            resp_pc_d     = redirect_target;
            drop_d        = outstanding_d;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            instr_id_d    = NOP_INSTR;
            instr_valid_d = 1'b0;
        end else begin
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = resp_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_rsp_data_i;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
                resp_pc_d              = resp_pc_q + XLEN'(4);
            end
            if (!stall_i) begin
                if (pop) begin
                    pc_id_d       = fifo_pc_q[rd_ptr_q];
                    instr_id_d    = fifo_instr_q[rd_ptr_q];
                    instr_valid_d = 1'b1;
                    rd_ptr_d      = rd_ptr_q + PTR_W'(1);
                end else begin
                    instr_id_d    = NOP_INSTR;
                    instr_valid_d = 1'b0;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_pc_q     <= '{default: '0};
            fifo_instr_q  <= '{default: '0};
            pc_id_q       <= '0;
            instr_id_q    <= NOP_INSTR;
            instr_valid_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
            pc_id_q       <= pc_id_d;
            instr_id_q    <= instr_id_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;
    assign PC_ID_o          = pc_id_q;
    assign instr_ID_o       = instr_id_q;
    assign instr_valid_o    = instr_valid_q;

    // Memory must not answer requests that were never accepted.
    a_rsp_has_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> (outstanding_q != '0));

    // The credit limit must keep the buffer from overflowing.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (count_q != CNT_W'(FIFO_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_riscv_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_if
// Description : Scoreboard bench for riscv_if with a latency-programmable
//               in-order instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_if;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic [31:0] PC_ID_o;
    logic [31:0] instr_ID_o;
    logic        instr_valid_o;

    always #5 clk_i = ~clk_i;

    riscv_if #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .PC_ID_o          (PC_ID_o),
        .instr_ID_o       (instr_ID_o),
        .instr_valid_o    (instr_valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks   = 0;
    int          errors   = 0;
    int          pops     = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    logic [31:0] last_pc  = 32'h0;
    logic [31:0] last_acc = 32'h0;
    logic        mon_held = 1'b0;
    logic [31:0] exp_q [$];
    mreq_t       mq [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory model: records accepted requests, answers in order after mem_lat cycles.
    initial begin
        mreq_t r;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && imem_req_valid_o && imem_req_ready_i) begin
                mq.push_back('{imem_req_addr_o, cyc + mem_lat});
                last_acc = imem_req_addr_o;
            end
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                mq.delete();
                imem_rsp_valid_i = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                r = mq.pop_front();
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mem_word(r.addr);
            end else begin
                imem_rsp_valid_i = 1'b0;
            end
        end
    end

    // Monitor: every freshly presented instruction is matched against the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && instr_valid_o && !mon_held) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual_pc=%h required=none", PC_ID_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_id", PC_ID_o, e);
                    check("instr_id", instr_ID_o, mem_word(e));
                    last_pc = e;
                    pops++;
                end
            end
            mon_held = stall_i && !redirect_i;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int n;
        int p0;
        logic found;
        logic [31:0] exp_addr;

        rst_ni           = 1'b0;
        imem_req_ready_i = 1'b1;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
        stall_i          = 1'b0;

        // Reset values.
        repeat (2) tick();
        @(negedge clk_i);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_instr", instr_ID_o, NOP);
        check("rst_pc", PC_ID_o, 32'h0);
        check("rst_req_addr", imem_req_addr_o, 32'h0);

        // Streaming from RESET_PC with 1-cycle memory latency.
        tick();
        rst_ni = 1'b1;
        push_stream(32'h0, 64);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_i);
            n++;
            if (i == 0) check("first_req_addr", imem_req_addr_o, 32'h0);
            if (instr_valid_o) found = 1'b1;
        end
        check("first_valid_latency", 32'(n), 32'd4);
        repeat (8) tick();
        check("stream_progress", 32'(pops >= 6), 32'h1);

        // Stall: outputs frozen, credit limit drops request valid.
        stall_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_pc", PC_ID_o, last_pc);
            check("stall_instr", instr_ID_o, mem_word(last_pc));
            check("stall_valid", 32'(instr_valid_o), 32'h1);
            tick();
        end
        check("credit_req_valid", 32'(imem_req_valid_o), 32'h0);
        stall_i = 1'b0;
        repeat (6) tick();

        // Redirect with requests in flight (2-cycle latency); low bits ignored.
        mem_lat = 2;
        repeat (6) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(negedge clk_i);
        check("redirect_req_valid", 32'(imem_req_valid_o), 32'h0);
        tick();
        redirect_i = 1'b0;
        exp_q.delete();
        push_stream(32'h100, 64);
        p0 = pops;
        @(negedge clk_i);
        check("redirect_valid", 32'(instr_valid_o), 32'h0);
        check("redirect_instr", instr_ID_o, NOP);
        check("redirect_pc_hold", PC_ID_o, last_pc);
        check("redirect_req_addr", imem_req_addr_o, 32'h100);
        check("redirect_req_valid_after", 32'(imem_req_valid_o), 32'h1);
        repeat (12) tick();
        check("redirect_progress", 32'(pops - p0 >= 3), 32'h1);

        // Redirect together with stall: redirect wins.
        stall_i = 1'b1;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        exp_q.delete();
        push_stream(32'h200, 64);
        @(negedge clk_i);
        check("redir_stall_valid", 32'(instr_valid_o), 32'h0);
        check("redir_stall_instr", instr_ID_o, NOP);
        repeat (8) tick();

        // Memory not ready: request held stable at the next sequential PC.
        imem_req_ready_i = 1'b0;
        tick();
        tick();
        exp_addr = last_acc + 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("notready_valid", 32'(imem_req_valid_o), 32'h1);
            check("notready_addr", imem_req_addr_o, exp_addr);
            tick();
        end
        imem_req_ready_i = 1'b1;
        repeat (8) tick();

        // Asynchronous reset mid-stream, observed before any clock edge.
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(instr_valid_o), 32'h0);
        check("async_rst_instr", instr_ID_o, NOP);
        check("async_rst_pc", PC_ID_o, 32'h0);
        repeat (2) tick();
        rst_ni = 1'b1;
        push_stream(32'h0, 64);
        p0 = pops;
        @(negedge clk_i);
        check("post_rst_req_addr", imem_req_addr_o, 32'h0);
        check("post_rst_req_valid", 32'(imem_req_valid_o), 32'h1);
        repeat (10) tick();
        check("post_rst_progress", 32'(pops - p0 >= 4), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
